// File: rtl/write_fifo_pkg.sv
// Shared constants and sizing helpers for the arbiter-side write FIFO.
package write_fifo_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int PTR_W_DEF      = DEPTH_LOG2_DEF + 1;

  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

  // Pointers and the occupancy count carry one extra wrap bit.
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/write_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_ram
  import write_fifo_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = fifo_depth(DEPTH_LOG2);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a shared address: the read sees the old entry.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/write_fifo.sv
// Single-clock FIFO behind the multi-writer arbiter; registered read data.
// Optional sticky overflow/underflow outputs under WRITE_FIFO_STATUS_EN.
module write_fifo
  import write_fifo_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_full,
  input  logic                  i_re,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_rvalid,
  output logic                  o_empty,
`ifdef WRITE_FIFO_STATUS_EN
  output logic                  o_overflow,
  output logic                  o_underflow,
`endif
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int PW    = ptr_width(DEPTH_LOG2);
  localparam int DEPTH = fifo_depth(DEPTH_LOG2);
  localparam logic [PW-1:0] WRAP = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          read_accept;
  logic          write_accept;

  // Status is a pure function of the registered pointers.
  assign o_full  = ((wr_ptr ^ rd_ptr) == WRAP);
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_count = wr_ptr - rd_ptr;

  assign read_accept  = !i_reset && i_re && !o_empty;
  assign write_accept = !i_reset && i_we && (!o_full || read_accept);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_rvalid <= 1'b0;
    end else begin
      if (write_accept) wr_ptr <= wr_ptr + PW'(1);
      if (read_accept)  rd_ptr <= rd_ptr + PW'(1);
      o_rvalid <= read_accept;
    end
  end

  fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (i_clk),
    .rst   (i_reset),
    .we    (write_accept),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (i_data),
    .re    (read_accept),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (o_data)
  );

`ifdef WRITE_FIFO_STATUS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_we && !write_accept) o_overflow  <= 1'b1;
      if (i_re && o_empty)       o_underflow <= 1'b1;
    end
  end
`endif

`ifdef FORMAL
  logic f_rst_seen;

  always_ff @(posedge i_clk) begin
    if (i_reset) f_rst_seen <= 1'b1;
  end

  always @(posedge i_clk) begin
    if (f_rst_seen && !i_reset) begin
      assert (o_count <= DEPTH);
      assert (o_full == (o_count == DEPTH));
      assert (o_empty == (o_count == 0));
      assert (!(o_full && o_empty));
    end
  end

`ifdef WRITE_FIFO_STATUS_EN
  // An arbiter that never strobes into a full FIFO can never overflow it.
  always @(posedge i_clk) begin
    assume (!(i_we && o_full));
    if (f_rst_seen) assert (!o_overflow);
  end
`endif
`endif

endmodule

// File: tb/tb_write_fifo.sv
// Scoreboard bench for write_fifo: queue-based reference model, directed
// scenarios followed by randomized traffic with occasional resets.
module tb_write_fifo;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                clk = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_we = 1'b0;
  logic [WIDTH-1:0]    i_data = '0;
  logic                i_re = 1'b0;
  logic                o_full;
  logic [WIDTH-1:0]    o_data;
  logic                o_rvalid;
  logic                o_empty;
  logic [DEPTH_LOG2:0] o_count;
`ifdef WRITE_FIFO_STATUS_EN
  logic                o_overflow;
  logic                o_underflow;
`endif

  write_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_we        (i_we),
    .i_data      (i_data),
    .o_full      (o_full),
    .i_re        (i_re),
    .o_data      (o_data),
    .o_rvalid    (o_rvalid),
    .o_empty     (o_empty),
`ifdef WRITE_FIFO_STATUS_EN
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
`endif
    .o_count     (o_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] mdl[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_last = '0;
  bit               exp_rvalid = 1'b0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  bit               mon_en = 1'b0;

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus; the model is advanced just after the edge.
  task automatic cycle(input bit rst, input bit we, input logic [WIDTH-1:0] d, input bit re);
    bit ra, wa;
    i_reset = rst;
    i_we    = we;
    i_data  = d;
    i_re    = re;
    ra = !rst && re && (mdl.size() > 0);
    wa = !rst && we && ((mdl.size() < DEPTH) || ra);
    @(posedge clk);
    #1;
    if (rst) begin
      mdl.delete();
      exp_rvalid = 1'b0;
      m_last     = '0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      if (we && !wa) m_ovf = 1'b1;
      if (re && mdl.size() == 0) m_unf = 1'b1;
      exp_rvalid = ra;
      if (ra) begin
        m_last = mdl.pop_front();
        exp_q.push_back(m_last);
      end
      if (wa) mdl.push_back(d);
    end
    mon_en = 1'b1;
    i_reset = 1'b0;
    i_we    = 1'b0;
    i_re    = 1'b0;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on o_rvalid.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("count", 32'(o_count), 32'(mdl.size()));
        check("full", 32'(o_full), 32'(mdl.size() == DEPTH));
        check("empty", 32'(o_empty), 32'(mdl.size() == 0));
        check("rvalid", 32'(o_rvalid), 32'(exp_rvalid));
        check("data_hold", 32'(o_data), 32'(m_last));
`ifdef WRITE_FIFO_STATUS_EN
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("underflow", 32'(o_underflow), 32'(m_unf));
`endif
        if (o_rvalid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("rdata_unexpected", 32'(o_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rdata", 32'(o_data), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    int pw, pr;
    // Reset then idle
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 0);

    // Fill then drain
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(i), 0);
    // Write while full, no read
    cycle(0, 1, 8'hAA, 0);
    cycle(0, 1, 8'hAA, 0);
    // Read and write together at full
    cycle(0, 1, 8'h55, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 0);

    // Read while empty with a simultaneous write: no fall-through
    cycle(0, 1, 8'h33, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);

    // Reset mid-operation alongside a write
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'hC0 + i), 0);
    cycle(1, 1, 8'hEE, 0);
    cycle(0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(8'h80 + i), 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, 1);

    // Randomized traffic with phases biased toward fill, drain and balance
    for (int i = 0; i < 800; i++) begin
      case ((i / 100) % 4)
        0: begin pw = 80; pr = 30; end
        1: begin pw = 30; pr = 80; end
        2: begin pw = 95; pr = 90; end
        default: begin pw = 50; pr = 50; end
      endcase
      cycle(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 99) < pw),
            8'($urandom),
            ($urandom_range(0, 99) < pr));
    end

    // Drain whatever remains, then confirm the scoreboard emptied
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
